uart_term_core: RTL and testbench

Parametrised full-duplex UART core with RX/TX FIFOs, runtime baud divisor, optional parity, sticky error flags and a hardware echo mode. It replaces the fixed 8N1 UART in the board terminal designs. It sits between the debounced push-button/switch logic and the seven-segment display logic; its FIFO ports are driven directly by single-cycle button pulses.

---
 rtl/uart_term_core.sv | 334 +++++++++++++++++++++++++++++++++
 tb/tb_uart_term_core.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_term_core.sv
// uart_term_core -- full-duplex UART with RX/TX FIFOs, runtime baud divisor,
// optional parity, sticky error flags and hardware echo.
//
// Ports:
//   clk, reset_n          system clock, asynchronous active-low reset
//   divisor               oversample tick period minus 1 (tick = clk/(divisor+1))
//   rx / tx               serial input (asynchronous) / serial output (idles high)
//   r_data, rd_uart       RX FIFO head (first-word-fall-through) and one-cycle pop
//   rx_empty, rx_count    RX FIFO status (registered)
//   w_data, wr_uart       byte to send and one-cycle push into the TX FIFO
//   tx_full, tx_idle      TX FIFO full; TX FIFO empty and transmitter idle
//   echo                  copy every stored RX byte into the TX FIFO
//   clr_err               clears the sticky error flags
//   parity_err, frame_err, overrun_err   sticky error flags

// Synchronous FIFO with registered empty/full/count and a combinational head.
module uart_term_fifo #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr,
    input  logic [DW-1:0] w_data,
    input  logic          rd,
    output logic [DW-1:0] r_data,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count_next;
    logic          do_push, do_pop;

    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign do_pop  = rd & ~empty;
    assign do_push = wr & (~full | do_pop);
    assign r_data  = empty ? '0 : mem[rd_ptr];

    // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_next = count;
        if (do_push && !do_pop)
            count_next = count + (AW+1)'(1);
        else if (do_pop && !do_push)
            count_next = count - (AW+1)'(1);
    end

    // NOTE: the storage array has no reset; the pointers and counters define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= w_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == FULL_CNT);
        end
    end
endmodule

module uart_term_core #(
    parameter int DBIT    = 8,
    parameter int PARITY  = 0,
    parameter int SB_TICK = 16,
    parameter int FIFO_W  = 4,
    parameter int DIV_W   = 11
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DIV_W-1:0]  divisor,
    input  logic              rx,
    output logic              tx,
    output logic [DBIT-1:0]   r_data,
    input  logic              rd_uart,
    output logic              rx_empty,
    output logic [FIFO_W:0]   rx_count,
    input  logic [DBIT-1:0]   w_data,
    input  logic              wr_uart,
    output logic              tx_full,
    output logic              tx_idle,
    input  logic              echo,
    input  logic              clr_err,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun_err
);
    localparam int S_W = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam logic [S_W-1:0] S_LAST = S_W'(15);
    localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICK - 1);
    localparam logic [2:0]     N_LAST = 3'(DBIT - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP_B} state_t;

    function automatic logic par_bit(input logic [DBIT-1:0] d);
        return (PARITY == 2) ? ~(^d) : (^d);
    endfunction

    // ---------------- baud tick ----------------
    logic [DIV_W-1:0] baud_cnt;
    logic             tick;

    assign tick = (baud_cnt == divisor);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            baud_cnt <= '0;
        else if (baud_cnt >= divisor)   // also recovers when divisor is lowered below the count
            baud_cnt <= '0;
        else
            baud_cnt <= baud_cnt + DIV_W'(1);
    end

    // ---------------- receiver ----------------
    logic            rx_meta, rx_sync;
    state_t          rx_state;
    logic [S_W-1:0]  rx_s;
    logic [2:0]      rx_n;
    logic [DBIT-1:0] rx_b;
    logic            rx_done, parity_evt, frame_evt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_state   <= S_IDLE;
            rx_s       <= '0;
            rx_n       <= '0;
            rx_b       <= '0;
            rx_done    <= 1'b0;
            parity_evt <= 1'b0;
            frame_evt  <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            rx_done    <= 1'b0;
            parity_evt <= 1'b0;
            frame_evt  <= 1'b0;
            case (rx_state)
                S_IDLE: if (!rx_sync) begin
                    rx_state <= S_START;
                    rx_s     <= '0;
                end
                S_START: if (tick) begin
                    if (rx_s == S_W'(7)) begin
                        // A line back high at mid-start is a glitch, not a frame.
                        rx_state <= rx_sync ? S_IDLE : S_DATA;
                        rx_s     <= '0;
                        rx_n     <= '0;
                    end else
                        rx_s <= rx_s + S_W'(1);
                end
                S_DATA: if (tick) begin
                    if (rx_s == S_LAST) begin
                        rx_s <= '0;
                        rx_b <= {rx_sync, rx_b[DBIT-1:1]};
                        if (rx_n == N_LAST)
                            rx_state <= (PARITY != 0) ? S_PARITY : S_STOP_B;
                        else
                            rx_n <= rx_n + 3'd1;
                    end else
                        rx_s <= rx_s + S_W'(1);
                end
                S_PARITY: if (tick) begin
                    if (rx_s == S_LAST) begin
                        rx_s       <= '0;
                        parity_evt <= (rx_sync != par_bit(rx_b));
                        rx_state   <= S_STOP_B;
                    end else
                        rx_s <= rx_s + S_W'(1);
                end
                S_STOP_B: if (tick) begin
                    if (rx_s == S_STOP) begin
                        rx_state  <= S_IDLE;
                        rx_done   <= rx_sync;
                        frame_evt <= ~rx_sync;
                    end else
                        rx_s <= rx_s + S_W'(1);
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end

    // ---------------- RX FIFO ----------------
    logic rx_full, overrun_evt, rx_stored;

    assign overrun_evt = rx_done & rx_full & ~(rd_uart & ~rx_empty);
    assign rx_stored   = rx_done & ~overrun_evt;

    uart_term_fifo #(.DW(DBIT), .AW(FIFO_W)) u_rx_fifo (
        .clk(clk), .reset_n(reset_n),
        .wr(rx_done), .w_data(rx_b), .rd(rd_uart),
        .r_data(r_data), .empty(rx_empty), .full(rx_full), .count(rx_count)
    );

    // ---------------- echo / TX FIFO write ----------------
    logic            echo_now, echo_pend, tx_push;
    logic [DBIT-1:0] echo_byte, tx_wdata;

    assign echo_now = echo & rx_stored;

    // User writes win; a colliding echo byte is parked for one cycle.
    always_comb begin
        tx_push  = 1'b0;
        tx_wdata = w_data;
        if (wr_uart) begin
            tx_push = 1'b1;
        end else if (echo_pend) begin
            tx_push  = 1'b1;
            tx_wdata = echo_byte;
        end else if (echo_now) begin
            tx_push  = 1'b1;
            tx_wdata = rx_b;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            echo_pend <= 1'b0;
            echo_byte <= '0;
        end else if (echo_now && (wr_uart || echo_pend)) begin
            echo_pend <= 1'b1;
            echo_byte <= rx_b;
        end else if (!wr_uart)
            echo_pend <= 1'b0;
    end

    // ---------------- transmitter ----------------
    state_t          tx_state;
    logic [S_W-1:0]  tx_s;
    logic [2:0]      tx_n;
    logic [DBIT-1:0] tx_b, tx_head;
    logic            tx_par, tx_reg, tx_empty, tx_pop;
    logic [FIFO_W:0] tx_count;

    assign tx_pop  = (tx_state == S_IDLE) & ~tx_empty;
    assign tx      = tx_reg;
    assign tx_idle = (tx_count == '0) & (tx_state == S_IDLE);

    uart_term_fifo #(.DW(DBIT), .AW(FIFO_W)) u_tx_fifo (
        .clk(clk), .reset_n(reset_n),
        .wr(tx_push), .w_data(tx_wdata), .rd(tx_pop),
        .r_data(tx_head), .empty(tx_empty), .full(tx_full), .count(tx_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state <= S_IDLE;
            tx_s     <= '0;
            tx_n     <= '0;
            tx_b     <= '0;
            tx_par   <= 1'b0;
            tx_reg   <= 1'b1;
        end else begin
            case (tx_state)
                S_IDLE: if (!tx_empty) begin
                    tx_reg   <= 1'b0;
                    tx_b     <= tx_head;
                    tx_par   <= par_bit(tx_head);
                    tx_s     <= '0;
                    tx_state <= S_START;
                end
                S_START: if (tick) begin
                    if (tx_s == S_LAST) begin
                        tx_s     <= '0;
                        tx_n     <= '0;
                        tx_reg   <= tx_b[0];
                        tx_state <= S_DATA;
                    end else
                        tx_s <= tx_s + S_W'(1);
                end
                S_DATA: if (tick) begin
                    if (tx_s == S_LAST) begin
                        tx_s <= '0;
                        tx_b <= tx_b >> 1;
                        if (tx_n == N_LAST) begin
                            tx_reg   <= (PARITY != 0) ? tx_par : 1'b1;
                            tx_state <= (PARITY != 0) ? S_PARITY : S_STOP_B;
                        end else begin
                            tx_n   <= tx_n + 3'd1;
                            tx_reg <= tx_b[1];
                        end
                    end else
                        tx_s <= tx_s + S_W'(1);
                end
                S_PARITY: if (tick) begin
                    if (tx_s == S_LAST) begin
                        tx_s     <= '0;
                        tx_reg   <= 1'b1;
                        tx_state <= S_STOP_B;
                    end else
                        tx_s <= tx_s + S_W'(1);
                end
                S_STOP_B: if (tick) begin
                    if (tx_s == S_STOP)
                        tx_state <= S_IDLE;
                    else
                        tx_s <= tx_s + S_W'(1);
                end
                default: tx_state <= S_IDLE;
            endcase
        end
    end

    // ---------------- sticky error flags ----------------
    // A new event in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            parity_err  <= parity_evt  | (parity_err  & ~clr_err);
            frame_err   <= frame_evt   | (frame_err   & ~clr_err);
            overrun_err <= overrun_evt | (overrun_err & ~clr_err);
        end
    end
endmodule

// File: tb/tb_uart_term_core.sv
// tb_uart_term_core -- directed bench for uart_term_core at divisor=3
// (one oversample tick per 4 clocks, one bit per 64 clocks).
// A second instance with odd parity covers the parity path.
module tb_uart_term_core;
    localparam int BIT = 64;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] divisor;
    logic        rx, rx_drv, loop_en;
    logic        tx;
    logic [7:0]  r_data;
    logic        rd_uart, rx_empty;
    logic [4:0]  rx_count;
    logic [7:0]  w_data;
    logic        wr_uart, tx_full, tx_idle, echo, clr_err;
    logic        parity_err, frame_err, overrun_err;

    logic        rxp_drv, txp;
    logic [7:0]  rp_data;
    logic        rp_empty, tp_full, tp_idle, pp_err, pf_err, po_err;
    logic [4:0]  rp_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign rx = loop_en ? tx : rx_drv;

    uart_term_core dut (
        .clk(clk), .reset_n(reset_n), .divisor(divisor), .rx(rx), .tx(tx),
        .r_data(r_data), .rd_uart(rd_uart), .rx_empty(rx_empty), .rx_count(rx_count),
        .w_data(w_data), .wr_uart(wr_uart), .tx_full(tx_full), .tx_idle(tx_idle),
        .echo(echo), .clr_err(clr_err), .parity_err(parity_err),
        .frame_err(frame_err), .overrun_err(overrun_err)
    );

    uart_term_core #(.PARITY(2)) dut_p (
        .clk(clk), .reset_n(reset_n), .divisor(divisor), .rx(rxp_drv), .tx(txp),
        .r_data(rp_data), .rd_uart(1'b0), .rx_empty(rp_empty), .rx_count(rp_count),
        .w_data(8'h00), .wr_uart(1'b0), .tx_full(tp_full), .tx_idle(tp_idle),
        .echo(1'b0), .clr_err(clr_err), .parity_err(pp_err),
        .frame_err(pf_err), .overrun_err(po_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        cycles(3);
        reset_n = 1'b1;
        cycles(5);
    endtask

    task automatic pulse(input int which);
        if (which == 0) wr_uart = 1'b1;
        else if (which == 1) rd_uart = 1'b1;
        else clr_err = 1'b1;
        @(negedge clk);
        wr_uart = 1'b0;
        rd_uart = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic drive(input int which, input logic v, input int n);
        if (which == 0) rx_drv = v;
        else rxp_drv = v;
        cycles(n);
    endtask

    // One 8-bit frame on rx (which=0) or on the parity instance (which=1).
    // A bad stop bit stays low only past the receiver's mid-bit sample.
    task automatic inject(input int which, input logic [7:0] d, input bit par_en,
                          input logic pbit, input bit stop_ok);
        drive(which, 1'b0, BIT);
        for (int i = 0; i < 8; i++) drive(which, d[i], BIT);
        if (par_en) drive(which, pbit, BIT);
        if (stop_ok) drive(which, 1'b1, BIT);
        else begin
            drive(which, 1'b0, 48);
            drive(which, 1'b1, 80);
        end
    endtask

    // Capture one frame from tx by mid-bit sampling after the falling edge.
    task automatic get_frame(output logic [7:0] d, output bit ok);
        int w;
        w  = 0;
        ok = 1'b0;
        d  = '0;
        while (tx !== 1'b0 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (tx !== 1'b0) return;
        cycles(BIT / 2);
        for (int i = 0; i < 8; i++) begin
            cycles(BIT);
            d[i] = tx;
        end
        cycles(BIT);
        ok = (tx === 1'b1);
    endtask

    logic wave [0:759];

    initial begin
        int         f, len, g, lat;
        logic [7:0] b, d1, d2;
        bit         ok1, ok2;

        reset_n = 1'b0;
        divisor = 11'd3;
        rx_drv  = 1'b1;
        rxp_drv = 1'b1;
        loop_en = 1'b0;
        rd_uart = 1'b0;
        wr_uart = 1'b0;
        w_data  = 8'h00;
        echo    = 1'b0;
        clr_err = 1'b0;
        cycles(4);
        reset_n = 1'b1;
        cycles(5);

        // ---- reset state ----
        check("rst_tx", tx, 1);
        check("rst_rx_empty", rx_empty, 1);
        check("rst_rx_count", rx_count, 0);
        check("rst_tx_full", tx_full, 0);
        check("rst_tx_idle", tx_idle, 1);
        check("rst_flags", {parity_err, frame_err, overrun_err}, 0);
        check("rst_r_data", r_data, 0);

        // ---- loopback 0xA5 ----
        loop_en = 1'b1;
        w_data  = 8'hA5;
        pulse(0);
        for (int i = 0; i < 760; i++) begin
            wave[i] = tx;
            @(negedge clk);
        end
        f = -1;
        for (int i = 0; i < 150; i++)
            if (f < 0 && wave[i] == 1'b0) f = i;
        check("lb_start_seen", (f >= 0), 1);
        if (f >= 0) begin
            len = 0;
            while (f + len < 760 && wave[f + len] == 1'b0) len++;
            check("lb_start_len", (len >= 61 && len <= 64), 1);
            b = '0;
            for (int k = 0; k < 8; k++) b[k] = wave[f + 32 + BIT * (k + 1)];
            check("lb_tx_bits", b, 8'hA5);
            check("lb_tx_stop", wave[f + 32 + BIT * 9], 1);
            g = f + len + BIT;
            len = 0;
            while (g + len < 760 && wave[g + len] == 1'b0) len++;
            check("lb_bit1_len", len, 64);
        end
        g = 0;
        while (rx_empty && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("lb_rx_empty", rx_empty, 0);
        check("lb_r_data", r_data, 8'hA5);
        pulse(1);
        check("lb_pop_empty", rx_empty, 1);
        check("lb_tx_idle", tx_idle, 1);
        loop_en = 1'b0;
        cycles(20);

        // ---- overrun: 17 bytes into a 16-entry FIFO ----
        for (int i = 0; i <= 16; i++) inject(0, 8'(i), 1'b0, 1'b0, 1'b1);
        cycles(4);
        check("ovr_count", rx_count, 16);
        check("ovr_flag", overrun_err, 1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("ovr_pop%0d", i), r_data, i);
            pulse(1);
        end
        check("ovr_drained", rx_empty, 1);
        pulse(2);
        check("ovr_clr", overrun_err, 0);

        // ---- odd parity on the second instance ----
        inject(1, 8'h01, 1'b1, 1'b1, 1'b1);
        cycles(4);
        check("par_err_set", pp_err, 1);
        check("par_stored", rp_count, 1);
        check("par_r_data", rp_data, 8'h01);
        inject(1, 8'h01, 1'b1, 1'b0, 1'b1);
        cycles(4);
        check("par_err_held", pp_err, 1);
        check("par_count2", rp_count, 2);
        pulse(2);
        inject(1, 8'h01, 1'b1, 1'b0, 1'b1);
        cycles(4);
        check("par_good_clean", pp_err, 0);
        check("par_count3", rp_count, 3);

        // ---- glitch then framing error ----
        drive(0, 1'b0, 16);
        drive(0, 1'b1, 400);
        check("glitch_flags", {parity_err, frame_err, overrun_err}, 0);
        check("glitch_empty", rx_empty, 1);
        inject(0, 8'h55, 1'b0, 1'b0, 1'b0);
        check("frame_err_set", frame_err, 1);
        check("frame_empty", rx_empty, 1);
        inject(0, 8'h5A, 1'b0, 1'b0, 1'b1);
        check("frame_then_good", rx_count, 1);

        // ---- reset during a TX data bit ----
        w_data = 8'h00;
        pulse(0);
        cycles(200);
        check("mid_tx_low", tx, 0);
        check("mid_tx_busy", tx_idle, 0);
        reset_n = 1'b0;
        #1;
        check("mid_rst_tx", tx, 1);
        check("mid_rst_idle", tx_idle, 1);
        check("mid_rst_count", rx_count, 0);
        check("mid_rst_flags", {parity_err, frame_err, overrun_err}, 0);
        cycles(3);
        reset_n = 1'b1;
        cycles(100);
        check("mid_after_tx", tx, 1);

        // ---- echo collision ----
        // First pass finds the store cycle relative to the frame start.
        echo = 1'b0;
        do_reset();
        lat = 0;
        fork
            inject(0, 8'h3C, 1'b0, 1'b0, 1'b1);
            begin
                while (rx_empty && lat < 2000) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        check("echo_cal_stored", rx_empty, 0);
        check("echo_cal_no_tx", tx_idle, 1);

        echo = 1'b1;
        do_reset();
        fork
            inject(0, 8'h3C, 1'b0, 1'b0, 1'b1);
            begin
                cycles(lat - 1);
                w_data = 8'h77;
                pulse(0);
                get_frame(d1, ok1);
                get_frame(d2, ok2);
            end
        join
        check("echo_first", d1, 8'h77);
        check("echo_first_stop", ok1, 1);
        check("echo_second", d2, 8'h3C);
        check("echo_second_stop", ok2, 1);
        check("echo_rx_count", rx_count, 1);
        check("echo_rx_data", r_data, 8'h3C);
        echo = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #10000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
